// File: rtl/polyphase_capture_ctrl_pkg.sv
// rtl/polyphase_capture_ctrl_pkg.sv - shared states and timing constants for the capture sequencer
package polyphase_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // The delay register needs two cycles to fill before the first valid pair.
  localparam int MIN_SETTLE = 2;
  localparam int PH_PERIOD  = 2;
  localparam int PH_W       = (PH_PERIOD > 1) ? $clog2(PH_PERIOD) : 1;

endpackage

// File: rtl/polyphase_capture_ctrl_phase_gen.sv
// rtl/polyphase_capture_ctrl_phase_gen.sv - downsample-phase strobe generator, phase 0 strobes
module polyphase_phase_gen
  import polyphase_capture_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic run_i,
  output logic stb_o
);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (run_i) begin
      phase_d = (phase_q == PH_W'(PH_PERIOD - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign stb_o = run_i && (phase_q == '0);

endmodule

// File: rtl/polyphase_capture_ctrl.sv
// rtl/polyphase_capture_ctrl.sv - capture sequencer: settle, alternate-cycle phase strobes, completion
module polyphase_capture_ctrl
  import polyphase_capture_ctrl_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int SET_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [SET_W-1:0] settle_cyc_i,
  input  logic [CNT_W-1:0] num_samp_i,
  output logic             enable_o,
  output logic             ph_stb_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] samp_cnt_o
);

  state_e           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             stb;
  logic             run;
  logic             phase_clr;

  assign run       = (state_q == ST_RUN);
  assign phase_clr = (state_q == ST_SETTLE) && (state_d == ST_RUN);

  polyphase_phase_gen u_phase_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (phase_clr),
    .run_i  (run),
    .stb_o  (stb)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          // Counter holds remaining settle cycles minus one so zero marks the last one.
          settle_d = (settle_cyc_i < SET_W'(MIN_SETTLE)) ? SET_W'(MIN_SETTLE - 1)
                                                         : settle_cyc_i - 1'b1;
          num_d    = num_samp_i;
          cnt_d    = '0;
          state_d  = (num_samp_i == '0) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (settle_q == '0) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (stb) begin
          cnt_d   = cnt_q + 1'b1;
          valid_d = !abort_i;
          if (cnt_d == num_q) begin
            state_d = ST_DRAIN;
          end
        end
        if (abort_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        state_d = abort_i ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  assign enable_o   = (state_q == ST_SETTLE) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign busy_o     = enable_o;
  assign done_o     = (state_q == ST_DONE);
  assign ph_stb_o   = stb;
  assign valid_o    = valid_q;
  assign samp_cnt_o = cnt_q;

endmodule

// File: tb/tb_polyphase_capture_ctrl.sv
// tb/tb_polyphase_capture_ctrl.sv - table-driven bench for the polyphase capture sequencer
module tb_polyphase_capture_ctrl;

  localparam int CNT_W = 10;
  localparam int SET_W = 8;

  typedef struct {
    logic             start;
    logic             abort;
    logic [SET_W-1:0] s;
    logic [CNT_W-1:0] n;
    logic             en;
    logic             stb;
    logic             v;
    logic             b;
    logic             d;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [SET_W-1:0] settle_cyc;
  logic [CNT_W-1:0] num_samp;
  logic             enable;
  logic             ph_stb;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] samp_cnt;

  int   n_applied;
  int   n_fail;
  vec_t vq[$];

  polyphase_capture_ctrl #(.CNT_W(CNT_W), .SET_W(SET_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .settle_cyc_i (settle_cyc),
    .num_samp_i   (num_samp),
    .enable_o     (enable),
    .ph_stb_o     (ph_stb),
    .valid_o      (valid),
    .busy_o       (busy),
    .done_o       (done),
    .samp_cnt_o   (samp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_applied++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic stb, input logic v,
                            input logic b, input logic d, input int cnt);
    check({tag, " enable"}, int'(enable), int'(en));
    check({tag, " ph_stb"}, int'(ph_stb), int'(stb));
    check({tag, " valid"}, int'(valid), int'(v));
    check({tag, " busy"}, int'(busy), int'(b));
    check({tag, " done"}, int'(done), int'(d));
    check({tag, " samp_cnt"}, int'(samp_cnt), cnt);
  endtask

  task automatic step(input logic st, input logic ab, input int s, input int n);
    start      = st;
    abort      = ab;
    settle_cyc = SET_W'(s);
    num_samp   = CNT_W'(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic st, input logic ab, input int s, input int n,
                     input logic en, input logic stb, input logic v, input logic b,
                     input logic d, input int cnt);
    vec_t r;
    r.start = st; r.abort = ab; r.s = SET_W'(s); r.n = CNT_W'(n);
    r.en = en; r.stb = stb; r.v = v; r.b = b; r.d = d; r.cnt = CNT_W'(cnt);
    vq.push_back(r);
  endtask

  initial begin
    n_applied  = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    settle_cyc = '0;
    num_samp   = '0;

    // Normal capture S=3 N=2
    add(1,0,3,2, 1,0,0,1,0,0);
    add(0,0,3,2, 1,0,0,1,0,0);
    add(0,0,3,2, 1,0,0,1,0,0);
    add(0,0,3,2, 1,1,0,1,0,0);
    add(0,0,3,2, 1,0,1,1,0,1);
    add(0,0,3,2, 1,1,0,1,0,1);
    add(0,0,3,2, 1,0,1,1,0,2);
    add(0,0,3,2, 0,0,0,0,1,2);
    add(0,0,3,2, 0,0,0,0,0,2);
    // Clamped settle, S=0 then S=1, N=1
    for (int s = 0; s < 2; s++) begin
      add(1,0,s,1, 1,0,0,1,0,0);
      add(0,0,s,1, 1,0,0,1,0,0);
      add(0,0,s,1, 1,1,0,1,0,0);
      add(0,0,s,1, 1,0,1,1,0,1);
      add(0,0,s,1, 0,0,0,0,1,1);
      add(0,0,s,1, 0,0,0,0,0,1);
    end
    // N=0: straight to DONE
    add(1,0,5,0, 0,0,0,0,1,0);
    add(0,0,5,0, 0,0,0,0,0,0);
    // Abort on the 2nd strobe, N=4
    add(1,0,2,4, 1,0,0,1,0,0);
    add(0,0,2,4, 1,0,0,1,0,0);
    add(0,0,2,4, 1,1,0,1,0,0);
    add(0,0,2,4, 1,0,1,1,0,1);
    add(0,0,2,4, 1,1,0,1,0,1);
    add(0,1,2,4, 0,0,0,0,0,2);
    add(0,0,2,4, 0,0,0,0,0,2);
    // ABORT beats START in IDLE
    add(1,1,3,2, 0,0,0,0,0,2);
    add(0,0,3,2, 0,0,0,0,0,2);
    // START held: back-to-back, mid-run NUM_SAMP change ignored
    add(1,0,2,1, 1,0,0,1,0,0);
    add(1,0,2,1, 1,0,0,1,0,0);
    add(1,0,2,1, 1,1,0,1,0,0);
    add(1,0,2,1, 1,0,1,1,0,1);
    add(1,0,2,1, 0,0,0,0,1,1);
    add(1,0,2,1, 0,0,0,0,0,1);
    add(1,0,2,1, 1,0,0,1,0,0);
    add(1,0,7,3, 1,0,0,1,0,0);
    add(1,0,7,3, 1,1,0,1,0,0);
    add(1,0,7,3, 1,0,1,1,0,1);
    add(1,0,7,3, 0,0,0,0,1,1);
    add(0,0,7,3, 0,0,0,0,0,1);
    add(0,0,7,3, 0,0,0,0,0,1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 0,0,0,0,0,0);
    rst_n = 1'b1;

    // Reset asserted mid-RUN at cycle 6 of a capture
    step(1,0,3,2);
    for (int c = 2; c <= 6; c++) step(0,0,3,2);
    check_outs("pre_reset c6", 1,1,0,1,0,1);
    #2 rst_n = 1'b0;
    #1 check_outs("async_reset", 0,0,0,0,0,0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0,0,3,2);
    check_outs("post_reset idle", 0,0,0,0,0,0);

    foreach (vq[i]) begin
      step(vq[i].start, vq[i].abort, int'(vq[i].s), int'(vq[i].n));
      check_outs($sformatf("vec%0d", i), vq[i].en, vq[i].stb, vq[i].v,
                 vq[i].b, vq[i].d, int'(vq[i].cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/polyphase_capture_ctrl.md
# polyphase_capture_ctrl

Sequencer for the 2-phase polyphase decimation path of the ADC TEG. It takes a capture request, enables the delay stage, and waits for the delay line to settle. It then issues a decimation-phase strobe on alternate cycles for a programmed number of output pairs and signals completion. It sits between the TEG register interface and the polyphase datapath and drives that path's enable and downsample-phase qualifier.

## Interface
- CNT_W, 10, width of sample-pair count
- SET_W, 8, width of settle-cycle count
- CLK  in  1  single system clock, all logic rising-edge
- RES  in  1  reset, asynchronous, active-low
- START  in  1  capture request, level sampled each cycle, acted on only in IDLE
- ABORT  in  1  synchronous abort, acted on in any state
- SETTLE_CYC  in  SET_W  settle cycles before first strobe, latched on accepted START
- NUM_SAMP  in  CNT_W  number of output pairs, latched on accepted START
- ENABLE  out  1  delay-stage enable to polyphase path
- PH_STB  out  1  one-cycle downsample-phase strobe (CLK_2 qualifier)
- VALID  out  1  output pair (OUT1/OUT2) valid, PH_STB delayed one cycle
- BUSY  out  1  capture in progress
- DONE  out  1  one-cycle completion pulse
- SAMP_CNT  out  CNT_W  pairs strobed in current/last capture

## Operation
- States: IDLE, SETTLE, RUN, DRAIN, DONE.
- IDLE: all outputs 0 except SAMP_CNT (held).
  - START=1 and ABORT=0: latch SETTLE_CYC and NUM_SAMP, clear SAMP_CNT.
  - NUM_SAMP!=0 → SETTLE; NUM_SAMP==0 → DONE directly (no ENABLE, no strobes).
- SETTLE: ENABLE=1, BUSY=1. Lasts max(SETTLE_CYC, 2) cycles; the 2-cycle minimum fills the delay register. Then → RUN.
- RUN: ENABLE=1, BUSY=1.
  - PH_STB=1 on the first RUN cycle and every second cycle after.
  - Each strobe increments SAMP_CNT (visible next cycle).
  - The cycle carrying the strobe that makes the count equal to the latched NUM_SAMP → DRAIN.
- DRAIN: one cycle, ENABLE=1, BUSY=1, VALID=1 for the last pair. → DONE.
- DONE: one cycle, DONE=1, BUSY=0, ENABLE=0. → IDLE.
- START outside IDLE is ignored, including in DONE. No queuing.
- ABORT=1 in SETTLE/RUN/DRAIN: → IDLE next edge.
  - ENABLE, PH_STB, VALID and BUSY drop next cycle. No DONE pulse. SAMP_CNT holds the partial count.
  - A VALID owed for a strobe in the abort cycle is suppressed.
- ABORT and START together in IDLE: ABORT wins, stay IDLE.
- SAMP_CNT never wraps: the maximum NUM_SAMP is 2^CNT_W-1, and counting stops at the latched value.
- Changes to SETTLE_CYC/NUM_SAMP during a capture have no effect.

## Timing
- Reset (RES=0): state IDLE, ENABLE=PH_STB=VALID=BUSY=DONE=0, SAMP_CNT=0, internal counters 0. Asynchronous assertion, synchronous-release behaviour only.
- START accepted at edge k → ENABLE=BUSY=1 from cycle k+1.
- First PH_STB at cycle k+1+max(S,2). Strobes every 2 cycles. Last strobe at k+1+max(S,2)+2(N-1).
- VALID = PH_STB delayed 1 cycle.
- DONE at last-strobe+2. BUSY falls with DONE.
- Earliest next accepted START: the cycle after DONE (IDLE).
- All outputs registered; no combinational input→output path.

## Structure
- Shared package: state enum, MIN_SETTLE=2 constant, PH_PERIOD=2 constant.
- One sub-module, polyphase_phase_gen: toggle-based strobe generator cleared on RUN entry, emits PH_STB on phase 0.
- Main module holds the FSM, settle counter, sample counter, and VALID/DONE registers.

## Test plan
- Reset mid-RUN (RES low at cycle 6 of a capture) → all outputs 0 immediately. After release, IDLE with SAMP_CNT=0.
- Normal capture, S=3, N=2, START at edge 0 → ENABLE 1..7, PH_STB at 4,6, VALID at 5,7, DONE at 8, SAMP_CNT=2.
- S=0 and S=1 each with N=1 → first PH_STB at cycle 3 (clamped settle), DONE at cycle 5.
- N=0 → no ENABLE, no PH_STB. DONE at cycle 1, BUSY never 1.
- ABORT in the cycle of the 2nd strobe (N=4) → PH_STB seen, SAMP_CNT=2, no VALID next cycle, no DONE, BUSY=0 next cycle.
- START held high continuously, S=2, N=1 → captures back-to-back: second ENABLE rises the cycle after the first DONE+1. START during BUSY has no effect. Latched N is not altered by NUM_SAMP changes mid-run.
